mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the DMem write port between the CPU and the UART
// programmer. In RUN the CPU owns the port. A rising edge on start_pg stalls
// the CPU and hands the port to the programmer through a one-word buffer.
// upg_done flushes that buffer and restarts the CPU at PC 0.
module mem_port_arbiter #(
    parameter int ADDR_W = 14,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start_pg,
    input  logic              upg_wen,
    input  logic [ADDR_W-1:0] upg_adr,
    input  logic [31:0]       upg_dat,
    input  logic              upg_done,
    input  logic              cpu_mem_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_stall,
    output logic              cpu_rst_req,
    output logic              upg_rst,
    output logic [1:0]        mode,
    output logic [CNT_W-1:0]  wr_count
);

    // The encoding is visible on the mode port, so keep these values fixed.
    typedef enum logic [1:0] {
        RUN   = 2'b00,
        DRAIN = 2'b01,
        PROG  = 2'b10,
        FLUSH = 2'b11
    } state_t;

    state_t              state;
    state_t              state_next;

    logic                start_prev;
    logic                start_armed;
    logic                start_rise;

    logic                buf_valid;
    logic [ADDR_W-1:0]   buf_addr;
    logic [31:0]         buf_data;
    logic                commit;

    logic                mem_we_raw;

    // start_armed stays clear after reset until start_pg has been sampled low.
    // A button held down through reset release therefore cannot start a session.
    assign start_rise = start_pg & ~start_prev & start_armed;

    // A word leaves the buffer in any cycle where the programmer owns the port
    // and the buffer holds data.
    assign commit = buf_valid & ((state == PROG) | (state == FLUSH));

    // Keep a one-cycle history of start_pg for edge detection.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            start_prev  <= 1'b0;
            start_armed <= 1'b0;
        end else begin
            start_prev  <= start_pg;
            start_armed <= start_armed | ~start_pg;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. DRAIN and FLUSH each last exactly one cycle.
    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (start_rise) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                state_next = PROG;
            end
            PROG: begin
                if (upg_done) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                state_next = RUN;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // One-word write buffer for the programmer. It is loaded only in PROG.
    // Each buffered word is written in the cycle after it is loaded, so the
    // valid flag simply follows upg_wen. A word that arrives together with
    // upg_done is still loaded, and FLUSH writes it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_data  <= '0;
        end else begin
            if ((state == PROG) && upg_wen) begin
                buf_valid <= 1'b1;
                buf_addr  <= upg_adr;
                buf_data  <= upg_dat;
            end else begin
                buf_valid <= 1'b0;
            end
        end
    end

    // Count the words written in this session. The count clears on the way
    // into PROG, saturates at its maximum, and holds its value in RUN so it
    // can be read back after the session ends.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_count <= '0;
        end else if (state == DRAIN) begin
            wr_count <= '0;
        end else if (commit && (wr_count != {CNT_W{1'b1}})) begin
            wr_count <= wr_count + CNT_W'(1);
        end
    end

    // Output decode. The CPU drives the DMem port only in RUN. In every other
    // state the port shows the buffer, and the write enable is set only when
    // a buffered word is actually being written.
    always_comb begin
        mem_we_raw  = 1'b0;
        mem_addr    = buf_addr;
        mem_wdata   = buf_data;
        cpu_stall   = 1'b1;
        cpu_rst_req = 1'b0;
        upg_rst     = 1'b1;
        case (state)
            RUN: begin
                mem_we_raw = cpu_mem_write;
                mem_addr   = cpu_addr;
                mem_wdata  = cpu_wdata;
                cpu_stall  = 1'b0;
            end
            DRAIN: begin
                mem_we_raw = 1'b0;
            end
            PROG: begin
                mem_we_raw = buf_valid;
                upg_rst    = 1'b0;
            end
            FLUSH: begin
                mem_we_raw  = buf_valid;
                cpu_rst_req = 1'b1;
            end
            default: begin
                mem_we_raw = 1'b0;
            end
        endcase
    end

    // Gate the write enable with reset. Otherwise the RUN passthrough would
    // let a CPU store reach DMem while the system is still held in reset.
    assign mem_we = mem_we_raw & rstn;
    assign mode   = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter. A second instance with CNT_W=2
// receives the same stimulus and is used to check counter saturation.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 14;

    logic              clk;
    logic              rstn;
    logic              start_pg;
    logic              upg_wen;
    logic [ADDR_W-1:0] upg_adr;
    logic [31:0]       upg_dat;
    logic              upg_done;
    logic              cpu_mem_write;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_stall;
    logic              cpu_rst_req;
    logic              upg_rst;
    logic [1:0]        mode;
    logic [15:0]       wr_count;

    logic              sat_mem_we;
    logic [ADDR_W-1:0] sat_mem_addr;
    logic [31:0]       sat_mem_wdata;
    logic              sat_cpu_stall;
    logic              sat_cpu_rst_req;
    logic              sat_upg_rst;
    logic [1:0]        sat_mode;
    logic [1:0]        sat_wr_count;

    int compared;
    int mismatched;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .CNT_W(16)) dut (
        .clk(clk), .rstn(rstn), .start_pg(start_pg),
        .upg_wen(upg_wen), .upg_adr(upg_adr), .upg_dat(upg_dat), .upg_done(upg_done),
        .cpu_mem_write(cpu_mem_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_stall(cpu_stall), .cpu_rst_req(cpu_rst_req), .upg_rst(upg_rst),
        .mode(mode), .wr_count(wr_count)
    );

    mem_port_arbiter #(.ADDR_W(ADDR_W), .CNT_W(2)) dut_sat (
        .clk(clk), .rstn(rstn), .start_pg(start_pg),
        .upg_wen(upg_wen), .upg_adr(upg_adr), .upg_dat(upg_dat), .upg_done(upg_done),
        .cpu_mem_write(cpu_mem_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .mem_we(sat_mem_we), .mem_addr(sat_mem_addr), .mem_wdata(sat_mem_wdata),
        .cpu_stall(sat_cpu_stall), .cpu_rst_req(sat_cpu_rst_req), .upg_rst(sat_upg_rst),
        .mode(sat_mode), .wr_count(sat_wr_count)
    );

    // Free-running clock with a 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog: stop the run if the sequence below ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compare one observed value with its expected value and record the result.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", tag, observed, expected);
        end
    endtask

    // Advance to 1 ns after the next rising edge. Inputs are driven here.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    // Wait 1 ns so combinational outputs settle before they are checked.
    task automatic settle();
        #1;
    endtask

    // Directed test sequence.
    initial begin
        compared      = 0;
        mismatched    = 0;
        rstn          = 1'b0;
        start_pg      = 1'b1;
        upg_wen       = 1'b0;
        upg_adr       = '0;
        upg_dat       = '0;
        upg_done      = 1'b0;
        cpu_mem_write = 1'b1;
        cpu_addr      = 14'h0001;
        cpu_wdata     = 32'h1;

        // Reset values. mem_we must stay low even though the CPU is storing.
        #3;
        checkOutput("rst_mode", mode, 2'b00);
        checkOutput("rst_mem_we", mem_we, 1'b0);
        checkOutput("rst_stall", cpu_stall, 1'b0);
        checkOutput("rst_rst_req", cpu_rst_req, 1'b0);
        checkOutput("rst_upg_rst", upg_rst, 1'b1);
        checkOutput("rst_wr_count", wr_count, 16'd0);

        applyStimulus();
        applyStimulus();
        cpu_mem_write = 1'b0;
        rstn = 1'b1;

        // start_pg is held high through reset release, so no session starts.
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("held_start_mode", mode, 2'b00);
        end

        // RUN passthrough of a CPU store.
        cpu_mem_write = 1'b1;
        cpu_addr      = 14'h0010;
        cpu_wdata     = 32'hDEADBEEF;
        settle();
        checkOutput("run_we", mem_we, 1'b1);
        checkOutput("run_addr", mem_addr, 14'h0010);
        checkOutput("run_wdata", mem_wdata, 32'hDEADBEEF);
        checkOutput("run_stall", cpu_stall, 1'b0);

        // upg_done and upg_wen are ignored in RUN.
        cpu_mem_write = 1'b0;
        upg_done = 1'b1;
        upg_wen  = 1'b1;
        upg_adr  = 14'h0099;
        upg_dat  = 32'h99;
        applyStimulus();
        checkOutput("run_done_ignored", mode, 2'b00);
        checkOutput("run_wen_dropped", mem_we, 1'b0);
        upg_done = 1'b0;
        upg_wen  = 1'b0;

        // Entry sequence: the mode goes 00, then 01, then 10.
        start_pg = 1'b0;
        applyStimulus();
        start_pg = 1'b1;
        cpu_mem_write = 1'b1;
        cpu_addr = 14'h0055;
        cpu_wdata = 32'h55;
        settle();
        checkOutput("entry_mode0", mode, 2'b00);
        applyStimulus();
        checkOutput("entry_mode1", mode, 2'b01);
        checkOutput("drain_we", mem_we, 1'b0);
        checkOutput("drain_stall", cpu_stall, 1'b1);
        checkOutput("drain_upg_rst", upg_rst, 1'b1);
        applyStimulus();
        checkOutput("entry_mode2", mode, 2'b10);
        checkOutput("prog_upg_rst", upg_rst, 1'b0);
        checkOutput("prog_wr_count0", wr_count, 16'd0);
        checkOutput("prog_we_idle", mem_we, 1'b0);

        // Burst of four words. The CPU store stays asserted and must be ignored.
        for (int i = 0; i < 4; i++) begin
            upg_wen = 1'b1;
            upg_adr = ADDR_W'(i);
            upg_dat = 32'hA0 + 32'(i);
            applyStimulus();
            checkOutput("burst_we", mem_we, 1'b1);
            checkOutput("burst_addr", mem_addr, 64'(i));
            checkOutput("burst_data", mem_wdata, 64'h00A0 + 64'(i));
            checkOutput("burst_count", wr_count, 64'(i));
        end
        upg_wen = 1'b0;
        applyStimulus();
        checkOutput("burst_idle_we", mem_we, 1'b0);
        checkOutput("burst_wr_count", wr_count, 16'd4);
        checkOutput("sat_after4", sat_wr_count, 2'd3);

        // Exit: the last word arrives together with upg_done.
        upg_wen  = 1'b1;
        upg_done = 1'b1;
        upg_adr  = 14'h3FFF;
        upg_dat  = 32'h12345678;
        applyStimulus();
        upg_wen  = 1'b0;
        upg_done = 1'b0;
        cpu_mem_write = 1'b0;
        settle();
        checkOutput("flush_mode", mode, 2'b11);
        checkOutput("flush_we", mem_we, 1'b1);
        checkOutput("flush_addr", mem_addr, 14'h3FFF);
        checkOutput("flush_data", mem_wdata, 32'h12345678);
        checkOutput("flush_rst_req", cpu_rst_req, 1'b1);
        checkOutput("flush_upg_rst", upg_rst, 1'b1);
        checkOutput("flush_stall", cpu_stall, 1'b1);
        applyStimulus();
        checkOutput("exit_mode", mode, 2'b00);
        checkOutput("exit_stall", cpu_stall, 1'b0);
        checkOutput("exit_rst_req", cpu_rst_req, 1'b0);
        checkOutput("exit_we", mem_we, 1'b0);
        checkOutput("exit_wr_count", wr_count, 16'd5);
        checkOutput("sat_wr_count", sat_wr_count, 2'd3);

        // New session, then a reset in the middle of a programmer write.
        start_pg = 1'b0;
        applyStimulus();
        start_pg = 1'b1;
        applyStimulus();
        checkOutput("s2_drain", mode, 2'b01);
        applyStimulus();
        checkOutput("s2_prog", mode, 2'b10);
        checkOutput("s2_wr_count_clr", wr_count, 16'd0);
        upg_wen = 1'b1;
        upg_adr = 14'h0007;
        upg_dat = 32'h77;
        @(negedge clk);
        rstn = 1'b0;
        settle();
        checkOutput("midrst_we", mem_we, 1'b0);
        checkOutput("midrst_mode", mode, 2'b00);
        checkOutput("midrst_upg_rst", upg_rst, 1'b1);
        checkOutput("midrst_wr_count", wr_count, 16'd0);
        applyStimulus();
        checkOutput("midrst_we_held", mem_we, 1'b0);
        upg_wen = 1'b0;
        start_pg = 1'b0;
        rstn = 1'b1;
        applyStimulus();
        checkOutput("post_rst_we", mem_we, 1'b0);
        checkOutput("post_rst_mode", mode, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
